// File: rtl/ttm4_seq_pkg.sv
// Shared encodings for the register-transfer sequencer: states, opcodes and the decoded control word.
package ttm4_seq_pkg;

    localparam logic [1:0] ST_FETCH = 2'b00;
    localparam logic [1:0] ST_EXEC  = 2'b01;
    localparam logic [1:0] ST_STORE = 2'b10;
    localparam logic [1:0] ST_HALT  = 2'b11;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOVI_A = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOVI_B = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_IM = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2,
        SRC_IN   = 2'd3
    } srcSel_t;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_A    = 2'd1,
        DST_B    = 2'd2,
        DST_OUT  = 2'd3
    } dstSel_t;

    // A PC load is carried by the jump bit rather than the destination field.
    typedef struct packed {
        srcSel_t src;
        dstSel_t dst;
        logic    jump;
        logic    carryUpd;
        logic    illegal;
    } ctrlWord_t;

    localparam ctrlWord_t CTRL_NOP = '{
        src:      SRC_NONE,
        dst:      DST_NONE,
        jump:     1'b0,
        carryUpd: 1'b0,
        illegal:  1'b0
    };

endpackage

// File: rtl/seq_decode.sv
// Opcode decoder: maps the IR opcode and the carry flag to a control word.
module seq_decode
    import ttm4_seq_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic       cf_i,
    output ctrlWord_t  ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_NOP;
        case (opcode_i)
            OP_ADD_A: begin
                ctrl_o.src      = SRC_A;
                ctrl_o.dst      = DST_A;
                ctrl_o.carryUpd = 1'b1;
            end
            OP_ADD_B: begin
                ctrl_o.src      = SRC_B;
                ctrl_o.dst      = DST_B;
                ctrl_o.carryUpd = 1'b1;
            end
            OP_MOVI_A: ctrl_o.dst = DST_A;
            OP_MOVI_B: ctrl_o.dst = DST_B;
            OP_MOV_AB: begin
                ctrl_o.src = SRC_B;
                ctrl_o.dst = DST_A;
            end
            OP_MOV_BA: begin
                ctrl_o.src = SRC_A;
                ctrl_o.dst = DST_B;
            end
            OP_IN_A: begin
                ctrl_o.src = SRC_IN;
                ctrl_o.dst = DST_A;
            end
            OP_IN_B: begin
                ctrl_o.src = SRC_IN;
                ctrl_o.dst = DST_B;
            end
            OP_OUT_B: begin
                ctrl_o.src = SRC_B;
                ctrl_o.dst = DST_OUT;
            end
            OP_OUT_IM: ctrl_o.dst  = DST_OUT;
            OP_JMP:    ctrl_o.jump = 1'b1;
            OP_JNC:    ctrl_o.jump = !cf_i;
            // 1000, 1010, 1100, 1101 are the only codes left over.
            default:   ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Three-phase FETCH/EXEC/STORE sequencer for a small register-transfer datapath.
// Define SEQ_HALT_ILLEGAL_EN to trap illegal opcodes in HALT instead of running them as NOP.
module reg_transfer_sequencer
    import ttm4_seq_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] ROMDATA,
    input  logic       CARRY_IN,
    input  logic       HOLD,
    output logic       nA_OUT,
    output logic       nB_OUT,
    output logic       nIN_OUT,
    output logic       nA_ST,
    output logic       nB_ST,
    output logic       nOUT_ST,
    output logic       nPC_LD,
    output logic       PC_INC,
    output logic [3:0] IMM,
    output logic       CF,
    output logic [1:0] STATE,
    output logic       HALTED
);

`ifdef SEQ_HALT_ILLEGAL_EN
    localparam logic HALT_ILLEGAL = 1'b1;
`else
    localparam logic HALT_ILLEGAL = 1'b0;
`endif

    logic [1:0] state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       cf_q, cf_d;
    ctrlWord_t  ctrl;
    logic       operandPhase;
    logic       storeFire;

    seq_decode uDecode (
        .opcode_i (ir_q[7:4]),
        .cf_i     (cf_q),
        .ctrl_o   (ctrl)
    );

    assign operandPhase = (state_q == ST_EXEC) || (state_q == ST_STORE);
    // Gating strobes with HOLD here is what delays a held store to the first free STORE cycle.
    assign storeFire    = (state_q == ST_STORE) && !HOLD;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cf_d    = cf_q;
        if (!HOLD) begin
            case (state_q)
                ST_FETCH: begin
                    ir_d    = ROMDATA;
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    state_d = (ctrl.illegal && HALT_ILLEGAL) ? ST_HALT : ST_STORE;
                end
                ST_STORE: begin
                    cf_d    = ctrl.carryUpd ? CARRY_IN : 1'b0;
                    state_d = ST_FETCH;
                end
                default: begin
                    state_d = HALT_ILLEGAL ? ST_HALT : ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_FETCH;
            ir_q    <= 8'h00;
            cf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cf_q    <= cf_d;
        end
    end

    always_comb begin
        nA_OUT  = 1'b1;
        nB_OUT  = 1'b1;
        nIN_OUT = 1'b1;
        nA_ST   = 1'b1;
        nB_ST   = 1'b1;
        nOUT_ST = 1'b1;
        nPC_LD  = 1'b1;
        PC_INC  = 1'b0;
        IMM     = 4'h0;
        if (operandPhase) begin
            IMM = ir_q[3:0];
            case (ctrl.src)
                SRC_A:   nA_OUT  = 1'b0;
                SRC_B:   nB_OUT  = 1'b0;
                SRC_IN:  nIN_OUT = 1'b0;
                default: ;
            endcase
        end
        if (storeFire) begin
            case (ctrl.dst)
                DST_A:   nA_ST   = 1'b0;
                DST_B:   nB_ST   = 1'b0;
                DST_OUT: nOUT_ST = 1'b0;
                default: ;
            endcase
            if (ctrl.jump) begin
                nPC_LD = 1'b0;
            end else begin
                PC_INC = 1'b1;
            end
        end
    end

    assign CF     = cf_q;
    assign STATE  = state_q;
    assign HALTED = HALT_ILLEGAL && (state_q == ST_HALT);

endmodule
